// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write scheduler.
// Sizes the write port and names the FSM states and round-robin sources.
package regfile_pkg;

  localparam int RF_NREGS = 32;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;

  typedef enum logic {S_INIT, S_RUN} rf_sched_state_t;

  // Encoding doubles as the request/grant bit index inside rr_arb2.
  typedef enum logic {SRC_LD, SRC_DBG} rf_src_t;

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Request and register-file write-port bundle for regfile_wr_sched.
// The slave side is the scheduler; the master side drives the requests and watches the write port.
interface regfile_wr_sched_if;
  import regfile_pkg::*;

  logic             wb_valid;
  logic [RF_AW-1:0] wb_rd;
  logic [RF_DW-1:0] wb_data;

  logic             ld_valid;
  logic             ld_ready;
  logic [RF_AW-1:0] ld_rd;
  logic [RF_DW-1:0] ld_data;

  logic             dbg_valid;
  logic             dbg_ready;
  logic [RF_AW-1:0] dbg_rd;
  logic [RF_DW-1:0] dbg_data;

  logic             init_done;
  logic             rf_wen;
  logic [RF_AW-1:0] rf_rd;
  logic [RF_DW-1:0] rf_rd_data;

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  ld_valid, ld_rd, ld_data,
    input  dbg_valid, dbg_rd, dbg_data,
    output ld_ready, dbg_ready, init_done,
    output rf_wen, rf_rd, rf_rd_data
  );

  modport master (
    output wb_valid, wb_rd, wb_data,
    output ld_valid, ld_rd, ld_data,
    output dbg_valid, dbg_rd, dbg_data,
    input  ld_ready, dbg_ready, init_done,
    input  rf_wen, rf_rd, rf_rd_data
  );

endinterface

// File: rtl/regfile_wr_sched_rr_arb2.sv
// Two-way round-robin arbiter, combinational grant, pointer moves away from the winner.
// Grants nothing while en is low; the pointer only advances on an actual grant.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output rf_src_t    ptr
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      gnt[0] = req[0] & ((ptr == SRC_LD)  | !req[1]);
      gnt[1] = req[1] & ((ptr == SRC_DBG) | !req[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= SRC_LD;
    end else if (gnt[0]) begin
      ptr <= SRC_DBG;
    end else if (gnt[1]) begin
      ptr <= SRC_LD;
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Owns the register-file write port: zero-sweep after reset, then wb > round-robin(ld, dbg).
// One cycle from grant to rf_wen; wb is never stalled, ld/dbg wait on ready, x0 writes are dropped.
module regfile_wr_sched
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  regfile_wr_sched_if.slave  bus
);

  localparam logic [RF_AW-1:0] LAST_REG = RF_AW'(RF_NREGS - 1);

  rf_sched_state_t  state, state_nxt;
  logic [RF_AW-1:0] cnt, cnt_nxt;
  logic             init_q, init_nxt;
  logic             wen_q, wen_nxt;
  logic [RF_AW-1:0] rd_q, rd_nxt;
  logic [RF_DW-1:0] data_q, data_nxt;

  logic             run;
  logic [1:0]       gnt;
  rf_src_t          ptr;

  // Ready is forced low during reset so nothing is handshaken that the reset would then drop.
  assign run = (state == S_RUN) && !rst;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.dbg_valid, bus.ld_valid}),
    .en  (run && !bus.wb_valid),
    .gnt (gnt),
    .ptr (ptr)
  );

  assign bus.ld_ready  = run && !bus.wb_valid && ((ptr == SRC_LD)  || !bus.dbg_valid);
  assign bus.dbg_ready = run && !bus.wb_valid && ((ptr == SRC_DBG) || !bus.ld_valid);

  assign bus.init_done  = init_q;
  assign bus.rf_wen     = wen_q;
  assign bus.rf_rd      = rd_q;
  assign bus.rf_rd_data = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_INIT;
      cnt    <= '0;
      init_q <= 1'b0;
      wen_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      init_q <= init_nxt;
      wen_q  <= wen_nxt;
      rd_q   <= rd_nxt;
      data_q <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_nxt  = init_q;
    wen_nxt   = 1'b0;
    rd_nxt    = rd_q;
    data_nxt  = data_q;
    case (state)
      S_INIT: begin
        wen_nxt  = 1'b1;
        rd_nxt   = cnt;
        data_nxt = '0;
        if (cnt == LAST_REG) begin
          state_nxt = S_RUN;
          init_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + RF_AW'(1);
        end
      end
      S_RUN: begin
        // A granted x0 write still consumes its slot but never reaches the register file.
        if (bus.wb_valid) begin
          wen_nxt = (bus.wb_rd != '0);
          if (wen_nxt) begin
            rd_nxt   = bus.wb_rd;
            data_nxt = bus.wb_data;
          end
        end else if (gnt[0]) begin
          wen_nxt = (bus.ld_rd != '0);
          if (wen_nxt) begin
            rd_nxt   = bus.ld_rd;
            data_nxt = bus.ld_data;
          end
        end else if (gnt[1]) begin
          wen_nxt = (bus.dbg_rd != '0);
          if (wen_nxt) begin
            rd_nxt   = bus.dbg_rd;
            data_nxt = bus.dbg_data;
          end
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: sweep, priority, round-robin, x0 filter, reset abort.
// Inputs change 1ns after posedge; outputs are sampled on the following negedge.
module tb_regfile_wr_sched;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  regfile_wr_sched_if rif ();

  regfile_wr_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (rif)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rif.wb_valid  = 1'b0; rif.wb_rd  = '0; rif.wb_data  = '0;
    rif.ld_valid  = 1'b0; rif.ld_rd  = '0; rif.ld_data  = '0;
    rif.dbg_valid = 1'b0; rif.dbg_rd = '0; rif.dbg_data = '0;
  endtask

  task automatic test_reset();
    logic [RF_AW-1:0] erd;
    logic             ewen;
    int               nwen;
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (rif.rf_wen !== 1'b0 || rif.rf_rd !== 5'd0 || rif.rf_rd_data !== 32'd0 || rif.init_done !== 1'b0)
      begin errors++; $display("FAIL reset_outputs: wen=%b rd=%0d data=%h done=%b, want 0/0/0/0",
                               rif.rf_wen, rif.rf_rd, rif.rf_rd_data, rif.init_done); end
    checks++;
    if (rif.ld_ready !== 1'b0 || rif.dbg_ready !== 1'b0)
      begin errors++; $display("FAIL reset_ready: ld=%b dbg=%b, want 0/0", rif.ld_ready, rif.dbg_ready); end
    next_cycle();
    rst  = 1'b0;
    nwen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      ewen = (k >= 2 && k <= 33);
      erd  = RF_AW'(k - 2);
      checks++;
      if (rif.rf_wen !== ewen)
        begin errors++; $display("FAIL sweep_wen c%0d: got %b want %b", k, rif.rf_wen, ewen); end
      if (ewen) begin
        checks++;
        if (rif.rf_rd !== erd || rif.rf_rd_data !== 32'd0)
          begin errors++; $display("FAIL sweep_addr c%0d: rd=%0d data=%h want rd=%0d data=0",
                                   k, rif.rf_rd, rif.rf_rd_data, erd); end
      end
      checks++;
      if (rif.init_done !== (k >= 33))
        begin errors++; $display("FAIL sweep_done c%0d: got %b want %b", k, rif.init_done, (k >= 33)); end
      checks++;
      if (rif.ld_ready !== (k >= 33))
        begin errors++; $display("FAIL sweep_ld_ready c%0d: got %b want %b", k, rif.ld_ready, (k >= 33)); end
      if (rif.rf_wen === 1'b1) nwen++;
      next_cycle();
    end
    checks++;
    if (nwen != 32)
      begin errors++; $display("FAIL sweep_count: %0d write cycles, want 32", nwen); end
  endtask

  task automatic test_wb();
    rif.wb_valid = 1'b1; rif.wb_rd = 5'd5; rif.wb_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (rif.ld_ready !== 1'b0 || rif.dbg_ready !== 1'b0)
      begin errors++; $display("FAIL wb_blocks_ready: ld=%b dbg=%b want 0/0", rif.ld_ready, rif.dbg_ready); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rif.rf_wen !== 1'b1 || rif.rf_rd !== 5'd5 || rif.rf_rd_data !== 32'hDEADBEEF)
      begin errors++; $display("FAIL wb_write: wen=%b rd=%0d data=%h want 1/5/deadbeef",
                               rif.rf_wen, rif.rf_rd, rif.rf_rd_data); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rif.rf_wen !== 1'b0 || rif.rf_rd !== 5'd5 || rif.rf_rd_data !== 32'hDEADBEEF)
      begin errors++; $display("FAIL idle_hold: wen=%b rd=%0d data=%h want 0/5/deadbeef",
                               rif.rf_wen, rif.rf_rd, rif.rf_rd_data); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic             eld;
    logic [RF_AW-1:0] erd;
    logic [RF_DW-1:0] edat;
    for (int c = 1; c <= 8; c++) begin
      rif.wb_valid  = (c <= 3); rif.wb_rd  = 5'd1; rif.wb_data  = 32'h11;
      rif.ld_valid  = (c <= 7); rif.ld_rd  = 5'd2; rif.ld_data  = 32'h22;
      rif.dbg_valid = (c <= 7); rif.dbg_rd = 5'd3; rif.dbg_data = 32'h33;
      @(negedge clk);
      if (c <= 3) begin
        checks++;
        if (rif.ld_ready !== 1'b0 || rif.dbg_ready !== 1'b0)
          begin errors++; $display("FAIL rr_wb_hold c%0d: ld=%b dbg=%b want 0/0", c, rif.ld_ready, rif.dbg_ready); end
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (rif.rf_wen !== 1'b1 || rif.rf_rd !== 5'd1 || rif.rf_rd_data !== 32'h11)
          begin errors++; $display("FAIL rr_wb_write c%0d: wen=%b rd=%0d data=%h want 1/1/11",
                                   c, rif.rf_wen, rif.rf_rd, rif.rf_rd_data); end
      end
      if (c >= 4 && c <= 7) begin
        eld = (c % 2 == 0);
        checks++;
        if (rif.ld_ready !== eld || rif.dbg_ready !== !eld)
          begin errors++; $display("FAIL rr_grant c%0d: ld=%b dbg=%b want %b/%b",
                                   c, rif.ld_ready, rif.dbg_ready, eld, !eld); end
      end
      if (c >= 5) begin
        erd  = (c % 2 == 1) ? 5'd2 : 5'd3;
        edat = (c % 2 == 1) ? 32'h22 : 32'h33;
        checks++;
        if (rif.rf_wen !== 1'b1 || rif.rf_rd !== erd || rif.rf_rd_data !== edat)
          begin errors++; $display("FAIL rr_write c%0d: wen=%b rd=%0d data=%h want 1/%0d/%h",
                                   c, rif.rf_wen, rif.rf_rd, rif.rf_rd_data, erd, edat); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_x0_filter();
    rif.ld_valid = 1'b1; rif.ld_rd = 5'd0; rif.ld_data = 32'h1234;
    @(negedge clk);
    checks++;
    if (rif.ld_ready !== 1'b1)
      begin errors++; $display("FAIL x0_ready: got %b want 1", rif.ld_ready); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rif.rf_wen !== 1'b0)
      begin errors++; $display("FAIL x0_wen: got %b want 0", rif.rf_wen); end
    next_cycle();
  endtask

  task automatic test_same_rd();
    rif.wb_valid = 1'b1; rif.wb_rd = 5'd7; rif.wb_data = 32'hA;
    rif.ld_valid = 1'b1; rif.ld_rd = 5'd7; rif.ld_data = 32'hB;
    @(negedge clk);
    checks++;
    if (rif.ld_ready !== 1'b0)
      begin errors++; $display("FAIL same_rd_hold: ld_ready=%b want 0", rif.ld_ready); end
    next_cycle();
    rif.wb_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rif.ld_ready !== 1'b1)
      begin errors++; $display("FAIL same_rd_ld_ready: got %b want 1", rif.ld_ready); end
    checks++;
    if (rif.rf_wen !== 1'b1 || rif.rf_rd !== 5'd7 || rif.rf_rd_data !== 32'hA)
      begin errors++; $display("FAIL same_rd_first: wen=%b rd=%0d data=%h want 1/7/a",
                               rif.rf_wen, rif.rf_rd, rif.rf_rd_data); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rif.rf_wen !== 1'b1 || rif.rf_rd !== 5'd7 || rif.rf_rd_data !== 32'hB)
      begin errors++; $display("FAIL same_rd_second: wen=%b rd=%0d data=%h want 1/7/b",
                               rif.rf_wen, rif.rf_rd, rif.rf_rd_data); end
    next_cycle();
  endtask

  task automatic test_rst_mid_sweep();
    logic             ewen;
    logic [RF_AW-1:0] erd;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rif.ld_ready !== 1'b0 || rif.dbg_ready !== 1'b0)
      begin errors++; $display("FAIL run_rst_ready: ld=%b dbg=%b want 0/0", rif.ld_ready, rif.dbg_ready); end
    next_cycle();
    rst = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      rst = (k == 18);
      @(negedge clk);
      ewen = (k >= 2 && k <= 18) || (k >= 20);
      erd  = (k >= 20) ? RF_AW'(k - 20) : RF_AW'(k - 2);
      checks++;
      if (rif.rf_wen !== ewen)
        begin errors++; $display("FAIL abort_wen c%0d: got %b want %b", k, rif.rf_wen, ewen); end
      if (ewen) begin
        checks++;
        if (rif.rf_rd !== erd)
          begin errors++; $display("FAIL abort_rd c%0d: got %0d want %0d", k, rif.rf_rd, erd); end
      end
      checks++;
      if (rif.init_done !== 1'b0)
        begin errors++; $display("FAIL abort_done c%0d: got %b want 0", k, rif.init_done); end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_wb();
    test_round_robin();
    test_x0_filter();
    test_same_rd();
    test_rst_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
